// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, two read ports, per-register pending scoreboard and a sequential clear sweep.
// Optional write-to-read bypass when the RF_BYPASS_EN macro is defined.
module regfile_mp #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              RF_clk,
   input  logic              RF_rst,
   input  logic              RF_ena,
   input  logic              WA_we,
   input  logic [ADDR_W-1:0] WA_addr,
   input  logic [DATA_W-1:0] WA_data,
   input  logic              WB_we,
   input  logic [ADDR_W-1:0] WB_addr,
   input  logic [DATA_W-1:0] WB_data,
   input  logic [ADDR_W-1:0] RA_addr,
   input  logic [ADDR_W-1:0] RB_addr,
   output logic [DATA_W-1:0] RA_data,
   output logic [DATA_W-1:0] RB_data,
   input  logic              SB_set,
   input  logic [ADDR_W-1:0] SB_addr,
   output logic              RA_busy,
   output logic              RB_busy,
   input  logic              CLR_req,
   output logic              CLR_busy
);

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_idx;
   logic [ADDR_W-1:0]   w_idx_nxt;
   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [DEPTH-1:0]    r_busy;

   logic                w_idle;
   logic                w_wa_acc;
   logic                w_wb_acc;
   logic                w_sb_acc;
   logic                w_clr_step;
   logic [DATA_W-1:0]   w_ra_data;
   logic [DATA_W-1:0]   w_rb_data;
   logic                w_ra_busy;
   logic                w_rb_busy;

   assign w_idle     = (r_state == S_IDLE);
   assign w_wa_acc   = RF_ena & w_idle & WA_we & (WA_addr != '0);
   assign w_wb_acc   = RF_ena & w_idle & WB_we & (WB_addr != '0);
   assign w_sb_acc   = RF_ena & w_idle & SB_set & (SB_addr != '0);
   assign w_clr_step = RF_ena & (r_state == S_CLEAR);

   always_ff @(posedge RF_clk or posedge RF_rst) begin
      if (RF_rst) begin
         r_state <= S_IDLE;
         r_idx   <= ADDR_W'(1);
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      case (r_state)
         S_IDLE: begin
            if (RF_ena && CLR_req) w_state_nxt = S_CLEAR;
         end
         S_CLEAR: begin
            if (RF_ena) begin
               if (r_idx == ADDR_W'(DEPTH - 1)) begin
                  w_state_nxt = S_IDLE;
                  w_idx_nxt   = ADDR_W'(1);
               end else begin
                  w_idx_nxt = r_idx + 1'b1;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Port B is applied after port A so it wins a same-address collision; set wins over a write's busy clear.
   always_ff @(posedge RF_clk or posedge RF_rst) begin
      if (RF_rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_busy <= '0;
      end else if (w_clr_step) begin
         r_mem[r_idx]  <= '0;
         r_busy[r_idx] <= 1'b0;
      end else begin
         if (w_wa_acc) begin
            r_mem[WA_addr]  <= WA_data;
            r_busy[WA_addr] <= 1'b0;
         end
         if (w_wb_acc) begin
            r_mem[WB_addr]  <= WB_data;
            r_busy[WB_addr] <= 1'b0;
         end
         if (w_sb_acc) r_busy[SB_addr] <= 1'b1;
      end
   end

   always_comb begin
      w_ra_data = (RA_addr != '0) ? r_mem[RA_addr] : '0;
      w_rb_data = (RB_addr != '0) ? r_mem[RB_addr] : '0;
      w_ra_busy = r_busy[RA_addr];
      w_rb_busy = r_busy[RB_addr];
`ifdef RF_BYPASS_EN
      if (w_wa_acc && WA_addr == RA_addr) begin
         w_ra_data = WA_data;
         w_ra_busy = 1'b0;
      end
      if (w_wb_acc && WB_addr == RA_addr) begin
         w_ra_data = WB_data;
         w_ra_busy = 1'b0;
      end
      if (w_wa_acc && WA_addr == RB_addr) begin
         w_rb_data = WA_data;
         w_rb_busy = 1'b0;
      end
      if (w_wb_acc && WB_addr == RB_addr) begin
         w_rb_data = WB_data;
         w_rb_busy = 1'b0;
      end
      if (w_sb_acc && SB_addr == RA_addr) w_ra_busy = 1'b1;
      if (w_sb_acc && SB_addr == RB_addr) w_rb_busy = 1'b1;
`endif
   end

   assign RA_data  = RF_ena ? w_ra_data : '0;
   assign RB_data  = RF_ena ? w_rb_data : '0;
   assign RA_busy  = RF_ena & w_ra_busy;
   assign RB_busy  = RF_ena & w_rb_busy;
   assign CLR_busy = (r_state == S_CLEAR);

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default parameters).
module tb_regfile_mp;

   logic        RF_clk = 1'b0;
   logic        RF_rst;
   logic        RF_ena;
   logic        WA_we, WB_we, SB_set, CLR_req;
   logic [4:0]  WA_addr, WB_addr, RA_addr, RB_addr, SB_addr;
   logic [31:0] WA_data, WB_data;
   logic [31:0] RA_data, RB_data;
   logic        RA_busy, RB_busy, CLR_busy;

   int n_checks = 0;
   int n_err    = 0;

   regfile_mp dut (
      .RF_clk(RF_clk), .RF_rst(RF_rst), .RF_ena(RF_ena),
      .WA_we(WA_we), .WA_addr(WA_addr), .WA_data(WA_data),
      .WB_we(WB_we), .WB_addr(WB_addr), .WB_data(WB_data),
      .RA_addr(RA_addr), .RB_addr(RB_addr),
      .RA_data(RA_data), .RB_data(RB_data),
      .SB_set(SB_set), .SB_addr(SB_addr),
      .RA_busy(RA_busy), .RB_busy(RB_busy),
      .CLR_req(CLR_req), .CLR_busy(CLR_busy)
   );

   always #5 RF_clk = ~RF_clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge RF_clk);
      #1;
   endtask

   task automatic fill_all();
      for (int i = 1; i < 32; i++) begin
         WA_we = 1'b1; WA_addr = 5'(i); WA_data = 32'h100 + 32'(i);
         cyc();
      end
      WA_we = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 32; i++) begin
         RA_addr = 5'(i); RB_addr = 5'(31 - i);
         #1;
         chk({tag, "_ra"}, RA_data, 32'h0);
         chk({tag, "_rb"}, RB_data, 32'h0);
         chk({tag, "_busy"}, {31'h0, RA_busy}, 32'h0);
      end
   endtask

   int cnt, guard;
   logic en;

   initial begin
      RF_rst = 1'b1; RF_ena = 1'b1;
      WA_we = 0; WB_we = 0; SB_set = 0; CLR_req = 0;
      WA_addr = 0; WB_addr = 0; RA_addr = 5; RB_addr = 9; SB_addr = 0;
      WA_data = 0; WB_data = 0;
      #12;
      chk("rst_ra", RA_data, 32'h0);
      chk("rst_rb", RB_data, 32'h0);
      chk("rst_clrbusy", {31'h0, CLR_busy}, 32'h0);
      chk("rst_busy", {30'h0, RA_busy, RB_busy}, 32'h0);
      RF_rst = 1'b0;
      cyc();

      // basic write / read, register 0 hardwired
      WA_we = 1; WA_addr = 5; WA_data = 32'h1234_5678; RA_addr = 5;
      cyc();
      WA_we = 0; #1;
      chk("wr5", RA_data, 32'h1234_5678);
      WA_we = 1; WA_addr = 0; WA_data = 32'hFFFF_FFFF; RA_addr = 0;
      cyc();
      WA_we = 0; #1;
      chk("wr0", RA_data, 32'h0);

      // same-address collision: port B wins
      WA_we = 1; WA_addr = 7; WA_data = 32'hAAAA_AAAA;
      WB_we = 1; WB_addr = 7; WB_data = 32'h5555_5555;
      cyc();
      WA_we = 0; WB_we = 0; RA_addr = 7; RB_addr = 7; #1;
      chk("coll_ra", RA_data, 32'h5555_5555);
      chk("coll_rb", RB_data, 32'h5555_5555);

      // scoreboard
      SB_set = 1; SB_addr = 9;
      cyc();
      SB_set = 0; RA_addr = 9; RB_addr = 8; #1;
      chk("sb_set", {31'h0, RA_busy}, 32'h1);
      chk("sb_other", {31'h0, RB_busy}, 32'h0);
      WB_we = 1; WB_addr = 9; WB_data = 32'h99;
      cyc();
      WB_we = 0; #1;
      chk("sb_wrclr", {31'h0, RA_busy}, 32'h0);
      SB_set = 1; SB_addr = 9; WA_we = 1; WA_addr = 9; WA_data = 32'h999;
      cyc();
      SB_set = 0; WA_we = 0; #1;
      chk("sb_setwins", {31'h0, RA_busy}, 32'h1);
      chk("sb_setwins_d", RA_data, 32'h999);
      SB_set = 1; SB_addr = 0;
      cyc();
      SB_set = 0; RA_addr = 0; #1;
      chk("sb_addr0", {31'h0, RA_busy}, 32'h0);

      // enable low: outputs zero, writes ignored
      RF_ena = 0; RA_addr = 9; RB_addr = 5;
      WA_we = 1; WA_addr = 5; WA_data = 32'hBAD0_BAD0; SB_set = 1; SB_addr = 5; #1;
      chk("ena0_ra", RA_data, 32'h0);
      chk("ena0_busy", {31'h0, RA_busy}, 32'h0);
      cyc();
      WA_we = 0; SB_set = 0; RF_ena = 1; #1;
      chk("ena0_wr", RB_data, 32'h1234_5678);
      chk("ena0_sb", {31'h0, RB_busy}, 32'h0);

      // bypass behaviour
      SB_set = 1; SB_addr = 3;
      cyc();
      SB_set = 0;
      WA_we = 1; WA_addr = 3; WA_data = 32'hDEAD_BEEF; RB_addr = 3; #1;
`ifdef RF_BYPASS_EN
      chk("byp_pre", RB_data, 32'hDEAD_BEEF);
      chk("byp_busy", {31'h0, RB_busy}, 32'h0);
`else
      chk("byp_pre", RB_data, 32'h0);
      chk("byp_busy", {31'h0, RB_busy}, 32'h1);
`endif
      cyc();
      WA_we = 0; #1;
      chk("byp_post", RB_data, 32'hDEAD_BEEF);
      chk("byp_post_busy", {31'h0, RB_busy}, 32'h0);

      // clear sweep with a pause and writes attempted throughout
      fill_all();
      SB_set = 1; SB_addr = 20;
      cyc();
      SB_set = 0;
      CLR_req = 1;
      cyc();
      CLR_req = 0; #1;
      chk("clr_start", {31'h0, CLR_busy}, 32'h1);
      WA_we = 1; WA_addr = 4; WA_data = 32'hFFFF_0000; SB_set = 1; SB_addr = 25;
      RA_addr = 31;
      cnt = 0; guard = 0;
      while (CLR_busy && guard < 200) begin
         guard++;
         en = !(guard >= 6 && guard <= 8);
         RF_ena = en;
         #1;
         if (guard == 3) chk("clr_read", RA_data, 32'h11F);
         if (guard == 7) chk("clr_pause_busy", {31'h0, CLR_busy}, 32'h1);
         if (en) cnt++;
         cyc();
      end
      WA_we = 0; SB_set = 0; RF_ena = 1;
      chk("clr_cycles", 32'(cnt), 32'd31);
      chk("clr_guard", 32'(guard), 32'd34);
      check_all_zero("clr");

      // reset aborts a sweep at cycle 10
      fill_all();
      CLR_req = 1;
      cyc();
      CLR_req = 0;
      for (int i = 0; i < 10; i++) cyc();
      RA_addr = 31; #1;
      chk("pre_rst", RA_data, 32'h11F);
      RF_rst = 1; #1;
      chk("rst_mid_busy", {31'h0, CLR_busy}, 32'h0);
      chk("rst_mid_data", RA_data, 32'h0);
      cyc();
      RF_rst = 0;
      cyc();
      chk("rst_after_busy", {31'h0, CLR_busy}, 32'h0);
      check_all_zero("rst");

      // index restarts at 1 after reset: a fresh sweep is 31 cycles
      CLR_req = 1;
      cyc();
      CLR_req = 0;
      cnt = 0;
      while (CLR_busy && cnt < 200) begin
         cnt++;
         cyc();
      end
      chk("clr2_cycles", 32'(cnt), 32'd31);
      WA_we = 1; WA_addr = 12; WA_data = 32'hC0FF_EE00; RA_addr = 12;
      cyc();
      WA_we = 0; #1;
      chk("post_clr_wr", RA_data, 32'hC0FF_EE00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
